arm_if_stage: RTL and testbench

Instruction-fetch stage of the five-stage ARM pipeline, directly upstream of the decode stage. Maintains the fetch PC, issues pipelined requests to instruction memory, buffers returned words in a small in-order fetch queue, and drives the IF/ID pipeline register consumed by decode. Honours decode's stall signals (`real_PCWrite`, `real_IFID_Write`), redirects on taken branches from execute, and stops fetching on halt.

---
 rtl/arm_if_stage.sv | 165 ++++++++++++++++
 tb/tb_arm_if_stage.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/arm_if_stage.sv
// ARM instruction-fetch stage: fetch PC, pipelined imem requests, in-order fetch queue and IF/ID register.
// Define ARM_IF_PC8_EN to make IFID_pc carry fetch address + 8 (r15 read value) instead of + 4.
module arm_if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 2            // 2..4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCWrite,
    input  logic        IFID_Write,
    input  logic        halt_req,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IFID_inst,
    output logic [31:0] IFID_pc,
    output logic        IFID_valid,
    output logic        fetch_halted
);

    localparam int          CW      = $clog2(FQ_DEPTH + 1);
    localparam int          PW      = $clog2(FQ_DEPTH);
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FQ_DEPTH);
    localparam logic [31:0] NOP     = 32'hE1A0_0000;
`ifdef ARM_IF_PC8_EN
    localparam logic [31:0] PC_OFS  = 32'd8;
`else
    localparam logic [31:0] PC_OFS  = 32'd4;
`endif

    logic [31:0]   r_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop_cnt;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_fl_rd_ptr;
    logic [PW-1:0] r_fl_wr_ptr;
    logic          r_halt_l;
    logic [31:0]   r_ifid_inst;
    logic [31:0]   r_ifid_pc;
    logic          r_ifid_valid;

    logic [31:0]   r_q_inst [FQ_DEPTH];
    logic [31:0]   r_q_pc   [FQ_DEPTH];
    logic [31:0]   r_fl_pc  [FQ_DEPTH];   // addresses of requests still awaiting a response

    logic [CW:0]   w_occupancy;
    logic          w_issue;
    logic          w_rsp_keep;
    logic [31:0]   w_rsp_pc;
    logic          w_pop;
    logic          w_bypass;
    logic          w_push;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(FQ_DEPTH - 1))
            return '0;
        return p + PW'(1);
    endfunction

    // Queue slots plus in-flight requests never exceed the queue size, so every response has a home.
    assign w_occupancy = {1'b0, r_count} + {1'b0, r_outstanding};
    assign imem_req    = ~rst & PCWrite & ~r_halt_l & ~branch_taken & (w_occupancy < DEPTH_W);
    assign imem_addr   = r_pc;
    assign w_issue     = imem_req & imem_gnt;

    assign w_rsp_keep  = imem_rvalid & (r_drop_cnt == '0);
    assign w_rsp_pc    = r_fl_pc[r_fl_rd_ptr];
    assign w_pop       = IFID_Write & ~branch_taken & (r_count != '0);
    assign w_bypass    = IFID_Write & ~branch_taken & (r_count == '0) & w_rsp_keep;
    assign w_push      = w_rsp_keep & ~branch_taken & ~w_bypass;

    assign IFID_inst    = r_ifid_inst;
    assign IFID_pc      = r_ifid_pc;
    assign IFID_valid   = r_ifid_valid;
    assign fetch_halted = r_halt_l & (r_outstanding == '0);

    // Storage arrays carry no reset; validity is tracked by the pointers and counts.
    always_ff @(posedge clk) begin
        if (w_issue)
            r_fl_pc[r_fl_wr_ptr] <= r_pc;
        if (w_push) begin
            r_q_inst[r_wr_ptr] <= imem_rdata;
            r_q_pc[r_wr_ptr]   <= w_rsp_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_fl_rd_ptr   <= '0;
            r_fl_wr_ptr   <= '0;
            r_halt_l      <= 1'b0;
            r_ifid_inst   <= NOP;
            r_ifid_pc     <= '0;
            r_ifid_valid  <= 1'b0;
        end else begin
            if (halt_req)
                r_halt_l <= 1'b1;

            if (branch_taken)
                r_pc <= branch_target;
            else if (w_issue)
                r_pc <= r_pc + 32'd4;

            case ({w_issue, imem_rvalid})
                2'b10:   r_outstanding <= r_outstanding + CW'(1);
                2'b01:   r_outstanding <= r_outstanding - CW'(1);
                default: ;
            endcase

            if (w_issue)
                r_fl_wr_ptr <= ptr_inc(r_fl_wr_ptr);
            if (imem_rvalid)
                r_fl_rd_ptr <= ptr_inc(r_fl_rd_ptr);

            // Everything still in flight at a redirect belongs to the wrong path.
            if (branch_taken)
                r_drop_cnt <= r_outstanding - CW'(imem_rvalid);
            else if (imem_rvalid && r_drop_cnt != '0)
                r_drop_cnt <= r_drop_cnt - CW'(1);

            if (branch_taken) begin
                r_count  <= '0;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push)
                    r_wr_ptr <= ptr_inc(r_wr_ptr);
                if (w_pop)
                    r_rd_ptr <= ptr_inc(r_rd_ptr);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: ;
                endcase
            end

            if (branch_taken || (IFID_Write && !w_pop && !w_bypass)) begin
                r_ifid_inst  <= NOP;
                r_ifid_pc    <= '0;
                r_ifid_valid <= 1'b0;
            end else if (w_pop) begin
                r_ifid_inst  <= r_q_inst[r_rd_ptr];
                r_ifid_pc    <= r_q_pc[r_rd_ptr] + PC_OFS;
                r_ifid_valid <= 1'b1;
            end else if (w_bypass) begin
                r_ifid_inst  <= imem_rdata;
                r_ifid_pc    <= w_rsp_pc + PC_OFS;
                r_ifid_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_arm_if_stage.sv
// Bench for arm_if_stage: bus-level memory model, fetch-order reference model and IF/ID scoreboard.
module tb_arm_if_stage;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'hE1A0_0000;
`ifdef ARM_IF_PC8_EN
    localparam logic [31:0] OFF = 32'd8;
`else
    localparam logic [31:0] OFF = 32'd4;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PCWrite = 1'b0;
    logic        IFID_Write = 1'b0;
    logic        halt_req = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] IFID_inst;
    logic [31:0] IFID_pc;
    logic        IFID_valid;
    logic        fetch_halted;

    arm_if_stage dut (
        .clk(clk), .rst(rst), .PCWrite(PCWrite), .IFID_Write(IFID_Write),
        .halt_req(halt_req), .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .IFID_inst(IFID_inst), .IFID_pc(IFID_pc), .IFID_valid(IFID_valid),
        .fetch_halted(fetch_halted)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [31:0] mpc; int ep; int due; } req_t;
    typedef struct { logic [31:0] inst; logic [31:0] pc; logic valid; } exp_t;

    req_t        memq[$];     // requests accepted by memory, oldest first
    exp_t        sb[$];       // words expected at IF/ID, in order
    exp_t        m_ifid;
    logic [31:0] m_pc = 32'h0;
    int          epoch = 0;
    bit          m_halt = 0;
    int          cyc = 0;
    bit          e_rst = 1, e_br = 0, e_wr = 0;
    int          errors = 0;
    int          checks = 0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5EED_C0DE;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
        end
    endtask

    task automatic drive_cycle(input bit r, input bit br, input logic [31:0] tgt, input bit wr,
                               input bit pcw, input bit hr, input bit g, input int lat);
        bit   rsp;
        bit   req_exp;
        req_t rq;
        @(negedge clk);
        cyc++;
        rsp = !r && memq.size() > 0 && memq[0].due <= cyc;
        rst = r; branch_taken = br; branch_target = tgt; IFID_Write = wr;
        PCWrite = pcw; halt_req = hr; imem_gnt = g;
        imem_rvalid = rsp;
        imem_rdata  = rsp ? mem_data(memq[0].addr) : $urandom;
        e_rst = r; e_br = br; e_wr = wr;
        #1;
        req_exp = !r && pcw && !m_halt && !br && (sb.size() + memq.size() < DEPTH);
        chk("imem_req", {31'b0, imem_req}, {31'b0, req_exp});
        if (r) begin
            memq.delete(); sb.delete();
            m_pc = 32'h0; epoch = 0; m_halt = 0;
        end else begin
            if (imem_req && g) begin
                chk("imem_addr", imem_addr, m_pc);
                rq = '{addr: imem_addr, mpc: m_pc, ep: epoch, due: cyc + lat};
                memq.push_back(rq);
                m_pc = m_pc + 32'd4;
            end
            if (rsp) begin
                rq = memq.pop_front();
                if (rq.ep == epoch && !br)
                    sb.push_back('{inst: mem_data(rq.mpc), pc: rq.mpc + OFF, valid: 1'b1});
            end
            if (br) begin
                sb.delete();
                epoch++;
                m_pc = tgt;
            end
            if (hr) m_halt = 1;
        end
        $display("cyc=%0d rst=%0b br=%0b wr=%0b pcw=%0b req=%0b addr=%h rv=%0b IFID=%h/%h/%0b", cyc, r, br, wr,
                 pcw, imem_req, imem_addr, rsp, IFID_inst, IFID_pc, IFID_valid);
    endtask

    // Monitor: one IF/ID observation per clock, after the edge settles.
    initial begin
        m_ifid = '{inst: NOP, pc: 32'h0, valid: 1'b0};
        forever begin
            @(posedge clk);
            #1;
            if (e_rst || e_br)
                m_ifid = '{inst: NOP, pc: 32'h0, valid: 1'b0};
            else if (e_wr) begin
                if (sb.size() > 0) m_ifid = sb.pop_front();
                else               m_ifid = '{inst: NOP, pc: 32'h0, valid: 1'b0};
            end
            chk("IFID_inst", IFID_inst, m_ifid.inst);
            chk("IFID_pc", IFID_pc, m_ifid.pc);
            chk("IFID_valid", {31'b0, IFID_valid}, {31'b0, m_ifid.valid});
            chk("fetch_halted", {31'b0, fetch_halted}, {31'b0, m_halt && memq.size() == 0});
            if (!e_rst)
                chk("occupancy_le_depth", {31'b0, (sb.size() + memq.size()) <= DEPTH}, 32'd1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] t;
        for (int i = 0; i < 3; i++) drive_cycle(1, 0, 0, 1, 1, 0, 1, 1);
        // zero-wait memory, continuous flow
        for (int i = 0; i < 20; i++) drive_cycle(0, 0, 0, 1, 1, 0, 1, 1);
        // decode stall for three cycles, then release
        for (int i = 0; i < 3; i++) drive_cycle(0, 0, 0, 0, 1, 0, 1, 1);
        for (int i = 0; i < 6; i++) drive_cycle(0, 0, 0, 1, 1, 0, 1, 1);
        // build two outstanding requests, then redirect to 0x100
        for (int i = 0; i < 4; i++) drive_cycle(0, 0, 0, 1, 1, 0, 1, 3);
        drive_cycle(0, 1, 32'h100, 1, 1, 0, 1, 1);
        for (int i = 0; i < 8; i++) drive_cycle(0, 0, 0, 1, 1, 0, 1, 1);
        // redirect to the top word: fetch address wraps to zero
        drive_cycle(0, 1, 32'hFFFF_FFFC, 1, 1, 0, 1, 1);
        for (int i = 0; i < 6; i++) drive_cycle(0, 0, 0, 1, 1, 0, 1, 1);
        // three-cycle memory latency
        for (int i = 0; i < 15; i++) drive_cycle(0, 0, 0, 1, 1, 0, 1, 3);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            t = $urandom;
            t[1:0] = 2'b00;
            if (i == 200) t = 32'hFFFF_FFF8;
            drive_cycle(0, ($urandom_range(0, 19) == 0) || (i == 200), t, $urandom_range(0, 4) != 0,
                        $urandom_range(0, 9) != 0, 0, $urandom_range(0, 3) != 0, int'($urandom_range(1, 4)));
        end
        for (int i = 0; i < 6; i++) drive_cycle(0, 0, 0, 1, 1, 0, 1, 1);
        // halt with a request in flight
        for (int i = 0; i < 2; i++) drive_cycle(0, 0, 0, 1, 1, 0, 1, 3);
        drive_cycle(0, 0, 0, 1, 1, 1, 1, 3);
        for (int i = 0; i < 15; i++) drive_cycle(0, 0, 0, 1, 1, 0, 1, 3);
        chk("fetch_halted_end", {31'b0, fetch_halted}, 32'd1);
        chk("undelivered_words", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
